window_buffer_ctrl: RTL and testbench
=====================================

Name: window_buffer_ctrl

Overview:
- Pointer/occupancy controller that sits directly in front of the multi-port instant buffer and drives its write_addr, read_addr and write_en.
- Accepts WRITE_SIZE-wide bursts from the upstream producer via a valid/ready handshake.
- Presents READ_SIZE-wide sliding windows to the downstream consumer and advances the window by POP_SIZE per accepted read.
- Handles circular wrap, full/empty, end-of-stream draining with partial windows, and synchronous flush.

Parameters:
- SIZE, 8: buffer depth in entries; must be a power of two.
- WRITE_SIZE, 2: entries written per accepted write; 1 <= WRITE_SIZE <= SIZE.
- READ_SIZE, 2: window width presented to the consumer; 1 <= READ_SIZE <= SIZE.
- POP_SIZE, 1: entries retired per accepted read; 1 <= POP_SIZE <= READ_SIZE.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- flush  input  1  synchronous clear of pointers, count and state.
- wr_valid  input  1  producer offers WRITE_SIZE entries.
- wr_last  input  1  qualifies the current write as the final burst of the stream.
- wr_ready  output  1  controller can accept a burst.
- write_en  output  1  buffer write strobe; equals wr_valid & wr_ready.
- write_addr  output  $clog2(SIZE)  first entry of the current burst.
- rd_ready  input  1  consumer accepts the current window.
- rd_valid  output  1  window at read_addr is valid.
- rd_partial  output  1  valid window holds fewer than READ_SIZE real entries (drain only).
- read_addr  output  $clog2(SIZE)  first entry of the current window.
- count  output  $clog2(SIZE+1)  current occupancy.
- full  output  1  count == SIZE.
- empty  output  1  count == 0.
- done  output  1  one-cycle pulse when a drain completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - wptr, rptr and count are 0; state is FILL; done is 0.
  - Resulting outputs: empty=1, full=0, wr_ready=1, rd_valid=0, rd_partial=0, write_en=0.
- Handshake signals (combinational from registered state):
  - wr_ready = (state==FILL) && (SIZE-count >= WRITE_SIZE).
  - wfire = wr_valid & wr_ready.
  - rd_valid: count >= READ_SIZE in FILL; count > 0 in DRAIN.
  - rfire = rd_valid & rd_ready.
  - wr_ready uses the current count only; a same-cycle pop does not free space early.
- Addresses: write_addr = wptr and read_addr = rptr, both combinational from registers.
- Pointer and count updates at the clock edge:
  - On wfire: wptr <= (wptr+WRITE_SIZE) mod SIZE.
  - On rfire: rptr <= (rptr+pop) mod SIZE.
  - pop = POP_SIZE in FILL; pop = min(POP_SIZE, count) in DRAIN.
  - count <= count + (wfire ? WRITE_SIZE : 0) - (rfire ? pop : 0).
  - wfire and rfire in the same cycle are both honoured.
- Visibility: data written at edge N can be in a window from cycle N+1 onward; there is no same-cycle bypass.
- FSM, two states:
  - FILL -> DRAIN on wfire with wr_last=1.
  - If the count after that write is 0, which only happens when WRITE_SIZE is 0 and cannot occur, DRAIN is still entered.
  - DRAIN: wr_ready=0, and wr_valid is ignored.
  - DRAIN -> FILL on the edge where count becomes 0; done=1 for exactly the following cycle.
  - Entering DRAIN with count already 0 is impossible because the last write adds WRITE_SIZE.
- rd_partial = (state==DRAIN) && (0 < count < READ_SIZE).
  - Window entries beyond count are don't-care; the consumer masks them.
- Flush (flush=1 at an edge):
  - Pointers and count go to 0 and state goes to FILL.
  - Same-cycle fires are discarded.
  - done is not pulsed.
- Reset mid-operation aborts everything immediately; no done pulse.
- Invariants:
  - count never exceeds SIZE and never goes below 0.
  - full and empty are never both 1.
  - count == (wptr-rptr) mod SIZE whenever count != SIZE.

Test Plan (defaults SIZE=8, WRITE_SIZE=2, READ_SIZE=2, POP_SIZE=1):
- Reset: drive rst=0 while bursts are active -> immediately count=0, write_addr=0, read_addr=0, empty=1, wr_ready=1, rd_valid=0, done=0.
- Fill to full: hold wr_valid=1 with rd_ready=0 -> write_addr 0,2,4,6 over four fires; count 2,4,6,8; wr_ready=0 and full=1 after the 4th edge; rd_valid=1 from count=2.
- Wrap: from full, set rd_ready=1 with wr_valid=0 -> read_addr 0,1,2; count 7,6; wr_ready=1 at count 6; the next write lands at write_addr=0 and rptr wraps 7 -> 0 correctly.
- Simultaneous: at count=4 (rptr=0, wptr=4), wr_valid=1 and rd_ready=1 for one cycle -> count=5, write_addr=6, read_addr=1.
- Drain: write 2 bursts, the second with wr_last=1 -> count=4 and wr_ready=0; pop continuously -> count 3,2,1,0; rd_partial=1 only at count=1; done=1 for exactly one cycle after count reaches 0; then wr_ready=1.
- Flush: at count=6 in DRAIN with rd_ready=1, assert flush -> next cycle count=0, pointers 0, state FILL, wr_ready=1, no done pulse.

Source files
------------

// File: rtl/window_buffer_ctrl.sv
// rtl/window_buffer_ctrl.sv - read/write pointer and occupancy controller for the multi-port window buffer
module window_buffer_ctrl #(
    parameter int SIZE       = 8,
    parameter int WRITE_SIZE = 2,
    parameter int READ_SIZE  = 2,
    parameter int POP_SIZE   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wr_valid,
    input  logic                      wr_last,
    output logic                      wr_ready,
    output logic                      write_en,
    output logic [$clog2(SIZE)-1:0]   write_addr,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic                      rd_partial,
    output logic [$clog2(SIZE)-1:0]   read_addr,
    output logic [$clog2(SIZE+1)-1:0] count,
    output logic                      full,
    output logic                      empty,
    output logic                      done
);

    localparam int AW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE + 1);

    localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
    localparam logic [CW-1:0] WS_C   = CW'(WRITE_SIZE);
    localparam logic [CW-1:0] RS_C   = CW'(READ_SIZE);
    localparam logic [CW-1:0] PS_C   = CW'(POP_SIZE);
    // SIZE is a power of two, so pointer wrap is plain truncation.
    localparam logic [AW-1:0] WS_A   = AW'(WRITE_SIZE % SIZE);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [AW-1:0] wptr, wptr_next;
    logic [AW-1:0] rptr, rptr_next;
    logic [CW-1:0] count_q, count_next;
    logic [CW-1:0] pop;
    logic          done_q, done_next;
    logic          wfire, rfire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FILL;
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            wptr    <= wptr_next;
            rptr    <= rptr_next;
            count_q <= count_next;
            done_q  <= done_next;
        end
    end

    always_comb begin
        wr_ready   = (state == FILL) && ((SIZE_C - count_q) >= WS_C);
        rd_valid   = (state == FILL) ? (count_q >= RS_C) : (count_q != '0);
        rd_partial = (state == DRAIN) && (count_q != '0) && (count_q < RS_C);
        wfire      = wr_valid && wr_ready;
        rfire      = rd_valid && rd_ready;

        // During drain the final window may be short; never retire more than is held.
        pop = ((state == DRAIN) && (count_q < PS_C)) ? count_q : PS_C;

        wptr_next  = wfire ? (wptr + WS_A) : wptr;
        rptr_next  = rfire ? (rptr + AW'(pop)) : rptr;
        count_next = count_q + (wfire ? WS_C : {CW{1'b0}}) - (rfire ? pop : {CW{1'b0}});

        state_next = state;
        done_next  = 1'b0;
        case (state)
            FILL: begin
                if (wfire && wr_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (count_next == '0) begin
                    state_next = FILL;
                    done_next  = 1'b1;
                end
            end
            default: state_next = FILL;
        endcase

        // Flush wins over any same-cycle traffic and suppresses the done pulse.
        if (flush) begin
            wptr_next  = '0;
            rptr_next  = '0;
            count_next = '0;
            state_next = FILL;
            done_next  = 1'b0;
        end
    end

    assign write_en   = wfire;
    assign write_addr = wptr;
    assign read_addr  = rptr;
    assign count      = count_q;
    assign full       = (count_q == SIZE_C);
    assign empty      = (count_q == '0);
    assign done       = done_q;

endmodule

// File: tb/tb_window_buffer_ctrl.sv
// tb/tb_window_buffer_ctrl.sv - scoreboard bench for window_buffer_ctrl with directed vectors
module tb_window_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_last = 1'b0;
    logic       rd_ready = 1'b0;
    logic       wr_ready, write_en, rd_valid, rd_partial, full, empty, done;
    logic [2:0] write_addr, read_addr;
    logic [3:0] count;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        string nm;
        int    cnt;
        int    wa;
        int    ra;
        logic  wrdy;
        logic  rv;
        logic  part;
        logic  dn;
        logic  wen;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    window_buffer_ctrl #(
        .SIZE(8), .WRITE_SIZE(2), .READ_SIZE(2), .POP_SIZE(1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_last(wr_last), .wr_ready(wr_ready),
        .write_en(write_en), .write_addr(write_addr),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_partial(rd_partial),
        .read_addr(read_addr), .count(count), .full(full), .empty(empty),
        .done(done)
    );

    task automatic chk(input string nm, input string f, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, f, act, req);
        end
    endtask

    // One cycle: drive inputs just after the edge, queue the outputs expected in this cycle.
    task automatic cyc(input logic rs, input logic wv, input logic wl, input logic rr,
                       input logic fl, input string nm, input int cnt, input int wa,
                       input int ra, input logic wrdy, input logic rv, input logic part,
                       input logic dn);
        exp_t e;
        @(posedge clk);
        #1;
        rst = rs; wr_valid = wv; wr_last = wl; rd_ready = rr; flush = fl;
        e.nm = nm; e.cnt = cnt; e.wa = wa; e.ra = ra; e.wrdy = wrdy;
        e.rv = rv; e.part = part; e.dn = dn; e.wen = wv & wrdy;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.nm, "count", int'(count), e.cnt);
                chk(e.nm, "write_addr", int'(write_addr), e.wa);
                chk(e.nm, "read_addr", int'(read_addr), e.ra);
                chk(e.nm, "wr_ready", int'(wr_ready), int'(e.wrdy));
                chk(e.nm, "rd_valid", int'(rd_valid), int'(e.rv));
                chk(e.nm, "rd_partial", int'(rd_partial), int'(e.part));
                chk(e.nm, "done", int'(done), int'(e.dn));
                chk(e.nm, "write_en", int'(write_en), int'(e.wen));
                chk(e.nm, "full", int'(full), (e.cnt == 8) ? 1 : 0);
                chk(e.nm, "empty", int'(empty), (e.cnt == 0) ? 1 : 0);
            end
        end
    end

    initial begin : stimulus
        //       rs wv wl rr fl  name      cnt wa ra wrdy rv part dn
        cyc(1, 0, 0, 0, 0, "rst_idle",  0, 0, 0, 1, 0, 0, 0);
        // fill to full
        cyc(1, 1, 0, 0, 0, "fill0",     0, 0, 0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, "fill1",     2, 2, 0, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, "fill2",     4, 4, 0, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, "fill3",     6, 6, 0, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, "full",      8, 0, 0, 0, 1, 0, 0);
        // pop from full, wrap both pointers
        cyc(1, 0, 0, 1, 0, "pop0",      8, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, "pop1",      7, 0, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, "pop2",      6, 0, 2, 1, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, "pop3",      5, 0, 3, 1, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, "pop4",      4, 0, 4, 1, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, "pop5",      3, 0, 5, 1, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, "pop6",      2, 0, 6, 1, 1, 0, 0);
        cyc(1, 1, 0, 1, 0, "low_wr",    1, 0, 7, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, "rwrap",     3, 2, 7, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, "rwrapped",  2, 2, 0, 1, 1, 0, 0);
        // flush discards same-cycle fires, then simultaneous read+write at count 4
        cyc(1, 1, 0, 1, 1, "fl_fires",  2, 2, 0, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, "sim_w0",    0, 0, 0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, "sim_w1",    2, 2, 0, 1, 1, 0, 0);
        cyc(1, 1, 0, 1, 0, "sim_rw",    4, 4, 0, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, "sim_after", 5, 6, 1, 1, 1, 0, 0);
        // drain with partial final window
        cyc(1, 0, 0, 0, 1, "dr_flush",  5, 6, 1, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, "dr_w0",     0, 0, 0, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, "dr_wlast",  2, 2, 0, 1, 1, 0, 0);
        cyc(1, 1, 0, 1, 0, "dr_c4",     4, 4, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, "dr_c3",     3, 4, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, "dr_c2",     2, 4, 2, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, "dr_c1",     1, 4, 3, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, "dr_done",   0, 4, 4, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, "dr_post",   0, 4, 4, 1, 0, 0, 0);
        // flush while draining at count 6
        cyc(1, 1, 0, 0, 0, "fd_w0",     0, 4, 4, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, "fd_w1",     2, 6, 4, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0, "fd_wlast",  4, 0, 4, 1, 1, 0, 0);
        cyc(1, 0, 0, 1, 1, "fd_flush",  6, 2, 4, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, "fd_after",  0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, "fd_nodone", 0, 0, 0, 1, 0, 0, 0);
        // asynchronous reset in the middle of a drain
        cyc(1, 1, 0, 0, 0, "ar_w0",     0, 0, 0, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, "ar_wlast",  2, 2, 0, 1, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, "ar_pop",    4, 4, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, "ar_reset",  0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, "ar_rel",    0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, "ar_nodone", 0, 0, 0, 1, 0, 0, 0);

        repeat (3) @(posedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain_queue actual=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
